// File: rtl/receiver_buffer_pkg.sv
// Shared definitions for the UART/AES comm blocks: block and byte geometry.
package receiver_buffer_pkg;

  localparam int unsigned BLOCK_W         = 128;
  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned BYTES_PER_BLOCK = BLOCK_W / BYTE_W;
  localparam int unsigned BYTE_CNT_W      = $clog2(BYTES_PER_BLOCK);

  typedef logic [BLOCK_W-1:0] block_t;
  typedef logic [BYTE_W-1:0]  byte_t;

endpackage

// File: rtl/fifo.sv
// First-word-fall-through block FIFO with registered head, sticky overflow
// and write acceptance when full if a pop lands in the same cycle.
module fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             empty_q, empty_d;
  logic             overflow_q, overflow_d;
  logic             full_c, empty_c, do_rd_c, do_wr_c;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;

    empty_c = (wr_ptr_q == rd_ptr_q);
    full_c  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    do_rd_c = rd_en && !empty_c;
    // A pop in the same cycle frees the slot a full-FIFO write needs.
    do_wr_c = wr_en && (!full_c || do_rd_c);

    if (do_wr_c) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (do_rd_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (wr_en && !do_wr_c) begin
      overflow_d = 1'b1;
    end

    empty_d = (wr_ptr_d == rd_ptr_d);
    head_d  = mem_d[rd_ptr_d[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      head_q     <= '0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      head_q     <= head_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  assign rd_data  = head_q;
  assign empty    = empty_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/receiver_buffer_rx_shift.sv
// Byte-to-block assembler: shifts UART bytes into a 128-bit register, emits a
// write strobe per 16 bytes and drops a stalled partial block on timeout.
module rx_shift
  import receiver_buffer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic   clk,
  input  logic   reset,
  input  byte_t  byte_in,
  input  logic   rx_done,
  output logic   wr_en,
  output block_t wr_data,
  output logic   frame_error
);

  localparam int unsigned TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [BYTE_CNT_W-1:0] CNT_LAST = BYTE_CNT_W'(BYTES_PER_BLOCK - 1);

  logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
  block_t                asm_q, asm_d;
  block_t                blk_q, blk_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  wr_q, wr_d;
  logic                  fe_q, fe_d;

  always_comb begin
    cnt_d = cnt_q;
    asm_d = asm_q;
    blk_d = blk_q;
    tmo_d = tmo_q;
    wr_d  = 1'b0;
    fe_d  = 1'b0;

    if (rx_done) begin
      asm_d = {asm_q[BLOCK_W-BYTE_W-1:0], byte_in};
      cnt_d = cnt_q + BYTE_CNT_W'(1);
      tmo_d = '0;
      if (cnt_q == CNT_LAST) begin
        wr_d  = 1'b1;
        blk_d = asm_d;
      end
    end else if ((TIMEOUT_CYCLES != 0) && (cnt_q != '0)) begin
      // A byte arriving on the expiry cycle takes the branch above instead.
      if (tmo_q == TMO_W'(TMO_LAST)) begin
        cnt_d = '0;
        asm_d = '0;
        tmo_d = '0;
        fe_d  = 1'b1;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      asm_q <= '0;
      blk_q <= '0;
      tmo_q <= '0;
      wr_q  <= 1'b0;
      fe_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
      blk_q <= blk_d;
      tmo_q <= tmo_d;
      wr_q  <= wr_d;
      fe_q  <= fe_d;
    end
  end

  assign wr_en       = wr_q;
  assign wr_data     = blk_q;
  assign frame_error = fe_q;

endmodule

// File: rtl/receiver_buffer.sv
// Receive buffer between UART receiver and AES control: packs bytes into
// 128-bit blocks and queues them in a FIFO for the AES side to pop.
module receiver_buffer
  import receiver_buffer_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BYTE_W-1:0]  byte_UART_to_shiftReg,
  input  logic               rx_done,
  input  logic               read_en,
  output logic [BLOCK_W-1:0] block_UART_rx_to_aes,
  output logic               empty,
  output logic               overflow,
  output logic               frame_error
);

  logic   blk_wr;
  block_t blk_data;

  rx_shift #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx_shift (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (byte_UART_to_shiftReg),
    .rx_done    (rx_done),
    .wr_en      (blk_wr),
    .wr_data    (blk_data),
    .frame_error(frame_error)
  );

  fifo #(
    .WIDTH(BLOCK_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (blk_wr),
    .wr_data (blk_data),
    .rd_en   (read_en),
    .rd_data (block_UART_rx_to_aes),
    .empty   (empty),
    .overflow(overflow)
  );

endmodule

// File: tb/tb_receiver_buffer.sv
// Directed self-checking bench for receiver_buffer (DEPTH=4, TIMEOUT_CYCLES=50).
module tb_receiver_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 50;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   byte_in;
  logic         rx_done;
  logic         read_en;
  logic [127:0] blk;
  logic         empty;
  logic         overflow;
  logic         frame_error;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;

  typedef struct {
    logic [7:0]   first;
    logic [7:0]   step;
    int           gap;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_error === 1'b1) fe_cnt++;

  receiver_buffer #(
    .DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .byte_UART_to_shiftReg(byte_in),
    .rx_done              (rx_done),
    .read_en              (read_en),
    .block_UART_rx_to_aes (blk),
    .empty                (empty),
    .overflow             (overflow),
    .frame_error          (frame_error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_done = 1'b1;
    byte_in = b;
    tick();
    rx_done = 1'b0;
    byte_in = 8'h00;
  endtask

  task automatic send_block(input logic [7:0] first, input logic [7:0] step, input int gap);
    for (int i = 0; i < 16; i++) begin
      send_byte(first + 8'(i) * step);
      if (i != 15) repeat (gap) tick();
    end
  endtask

  task automatic pop();
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [127:0] mk_block(input logic [7:0] first);
    logic [127:0] b = '0;
    for (int i = 0; i < 16; i++) b = {b[119:0], first + 8'(i)};
    return b;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    vecs[0] = '{8'h00, 8'h01, 10, 128'h000102030405060708090A0B0C0D0E0F};
    vecs[1] = '{8'hF8, 8'h01, 0,  128'hF8F9FAFBFCFDFEFF0001020304050607};
    vecs[2] = '{8'h5A, 8'h00, 2,  128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A};
    vecs[3] = '{8'h01, 8'h11, 1,  128'h0112233445566778899AABBCCDDEEF00};

    reset   = 1'b1;
    rx_done = 1'b0;
    read_en = 1'b0;
    byte_in = 8'h00;
    repeat (2) tick();
    reset = 1'b0;

    chk("rst_empty", 128'(empty), 128'd1);
    chk("rst_overflow", 128'(overflow), 128'd0);
    chk("rst_frame_error", 128'(frame_error), 128'd0);
    chk("rst_block", blk, 128'd0);

    pop();
    chk("pop_on_empty", 128'(empty), 128'd1);

    // Single-block vectors: latency, content, pop back to empty.
    for (int v = 0; v < 4; v++) begin
      send_block(vecs[v].first, vecs[v].step, vecs[v].gap);
      chk($sformatf("v%0d_latency_empty", v), 128'(empty), 128'd1);
      tick();
      chk($sformatf("v%0d_empty", v), 128'(empty), 128'd0);
      chk($sformatf("v%0d_block", v), blk, vecs[v].exp);
      chk($sformatf("v%0d_overflow", v), 128'(overflow), 128'd0);
      pop();
      chk($sformatf("v%0d_popped_empty", v), 128'(empty), 128'd1);
    end

    // 32 back-to-back bytes produce two blocks.
    send_block(8'h10, 8'h01, 0);
    send_block(8'h20, 8'h01, 0);
    tick();
    chk("b2b_first", blk, 128'h101112131415161718191A1B1C1D1E1F);
    pop();
    chk("b2b_second", blk, 128'h202122232425262728292A2B2C2D2E2F);
    chk("b2b_not_empty", 128'(empty), 128'd0);
    pop();
    chk("b2b_empty", 128'(empty), 128'd1);
    chk("b2b_overflow", 128'(overflow), 128'd0);

    // Five blocks without reads: fifth dropped, overflow sticky.
    for (int k = 0; k < 5; k++) send_block(8'h30 + 8'(16 * k), 8'h01, 0);
    repeat (2) tick();
    chk("ovf_set", 128'(overflow), 128'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ovf_order%0d", k), blk, mk_block(8'h30 + 8'(16 * k)));
      pop();
    end
    chk("ovf_drained_empty", 128'(empty), 128'd1);
    chk("ovf_sticky", 128'(overflow), 128'd1);

    // Reset mid-block with two blocks queued and overflow set.
    send_block(8'h80, 8'h01, 0);
    send_block(8'h90, 8'h01, 0);
    for (int i = 0; i < 9; i++) send_byte(8'hC0 + 8'(i));
    do_reset();
    chk("mid_rst_empty", 128'(empty), 128'd1);
    chk("mid_rst_overflow", 128'(overflow), 128'd0);
    chk("mid_rst_block", blk, 128'd0);
    send_block(8'hD0, 8'h01, 0);
    tick();
    chk("post_rst_block", blk, mk_block(8'hD0));
    pop();
    chk("post_rst_empty", 128'(empty), 128'd1);

    // Full FIFO with a pop landing on the fifth write: nothing dropped.
    for (int k = 0; k < 4; k++) send_block(8'h30 + 8'(16 * k), 8'h01, 0);
    send_block(8'h70, 8'h01, 0);
    pop();
    chk("concur_overflow", 128'(overflow), 128'd0);
    for (int k = 1; k < 5; k++) begin
      chk($sformatf("concur_order%0d", k), blk, mk_block(8'h30 + 8'(16 * k)));
      pop();
    end
    chk("concur_empty", 128'(empty), 128'd1);
    chk("concur_overflow_end", 128'(overflow), 128'd0);

    // Timeout: 7 bytes then silence.
    base = fe_cnt;
    for (int i = 0; i < 7; i++) send_byte(8'h11 + 8'(i));
    repeat (TMO - 1) tick();
    chk("tmo_not_yet", 128'(frame_error), 128'd0);
    tick();
    chk("tmo_pulse", 128'(frame_error), 128'd1);
    tick();
    chk("tmo_pulse_end", 128'(frame_error), 128'd0);
    chk("tmo_fifo_empty", 128'(empty), 128'd1);
    repeat (60) tick();
    chk("tmo_pulse_count", 128'(fe_cnt - base), 128'd1);
    send_block(8'hA0, 8'h01, 0);
    tick();
    chk("tmo_clean_block", blk, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
    pop();

    // Expiry race: a byte on the boundary cycle is accepted.
    base = fe_cnt;
    for (int i = 0; i < 7; i++) send_byte(8'hE0 + 8'(i));
    repeat (TMO - 1) tick();
    send_byte(8'hE7);
    chk("race_no_error", 128'(frame_error), 128'd0);
    for (int i = 8; i < 16; i++) send_byte(8'hE0 + 8'(i));
    tick();
    chk("race_block", blk, 128'hE0E1E2E3E4E5E6E7E8E9EAEBECEDEEEF);
    chk("race_not_empty", 128'(empty), 128'd0);
    chk("race_pulse_count", 128'(fe_cnt - base), 128'd0);
    pop();
    chk("race_empty", 128'(empty), 128'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
